byte_serial_add_ctrl: RTL and testbench

//  Sequences one 8-bit ripple_add to add two NBYTES-wide operands, one byte per cycle, LSB byte first.
//  A carry register links each byte to the next.

---
 rtl/add_pkg.sv | 17 +
 rtl/ripple_add.sv | 25 ++
 rtl/byte_serial_add_ctrl.sv | 125 ++++++++++++
 tb/tb_byte_serial_add_ctrl.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/add_pkg.sv
// Shared constants and types for the byte-serial adder controller and its datapath.
package add_pkg;

    localparam int BYTE_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // Width of the byte index; never zero, so a single-byte build still has a usable register.
    function automatic int idx_width(input int nbytes);
        return (nbytes > 1) ? $clog2(nbytes) : 1;
    endfunction

endpackage

// File: rtl/ripple_add.sv
// 8-bit ripple-carry adder used as the shared byte datapath.
module ripple_add
    import add_pkg::*;
(
    input  logic [BYTE_W-1:0] a,
    input  logic [BYTE_W-1:0] b,
    input  logic              cin,
    output logic [BYTE_W-1:0] sum,
    output logic              cout
);

    logic [BYTE_W:0] carry;

    always_comb begin
        sum      = '0;
        carry    = '0;
        carry[0] = cin;
        for (int i = 0; i < BYTE_W; i++) begin
            sum[i]       = a[i] ^ b[i] ^ carry[i];
            carry[i + 1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
        end
        cout = carry[BYTE_W];
    end

endmodule

// File: rtl/byte_serial_add_ctrl.sv
// Adds two NBYTES-wide operands one byte per cycle through a single ripple_add, LSB byte first.
// Optional macro SUBTRACT_EN adds an op_sub port that turns the operation into A-B.
module byte_serial_add_ctrl
    import add_pkg::*;
#(
    parameter int NBYTES = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [BYTE_W*NBYTES-1:0] a,
    input  logic [BYTE_W*NBYTES-1:0] b,
    input  logic                     c_in,
`ifdef SUBTRACT_EN
    input  logic                     op_sub,
`endif
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [BYTE_W*NBYTES-1:0] sum,
    output logic                     c_out,
    output logic                     busy
);

    localparam int               IDX_W    = idx_width(NBYTES);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBYTES - 1);

    state_e                        state_q, state_d;
    logic [IDX_W-1:0]              idx_q, idx_d;
    logic                          carry_q, carry_d;
    logic                          c_out_q, c_out_d;
    logic                          sub_q, sub_d;
    logic [NBYTES-1:0][BYTE_W-1:0] a_q, a_d;
    logic [NBYTES-1:0][BYTE_W-1:0] b_q, b_d;
    logic [NBYTES-1:0][BYTE_W-1:0] sum_q, sum_d;

    logic [BYTE_W-1:0] add_a, add_b, add_sum;
    logic              add_cout;

    // Subtraction is A + ~B + 1: B is inverted here, the +1 is the initial carry set at accept.
    assign add_a = a_q[idx_q];
    assign add_b = sub_q ? ~b_q[idx_q] : b_q[idx_q];

    ripple_add u_add (
        .a    (add_a),
        .b    (add_b),
        .cin  (carry_q),
        .sum  (add_sum),
        .cout (add_cout)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            carry_q <= 1'b0;
            c_out_q <= 1'b0;
            sub_q   <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            c_out_q <= c_out_d;
            sub_q   <= sub_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        c_out_d = c_out_q;
        sub_d   = sub_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = a;
                    b_d     = b;
                    idx_d   = '0;
`ifdef SUBTRACT_EN
                    sub_d   = op_sub;
                    carry_d = op_sub ? 1'b1 : c_in;
`else
                    carry_d = c_in;
`endif
                    state_d = RUN;
                end
            end
            RUN: begin
                sum_d[idx_q] = add_sum;
                carry_d      = add_cout;
                if (idx_q == LAST_IDX) begin
                    c_out_d = add_cout;
                    state_d = DONE;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state_q == IDLE);
        out_valid = (state_q == DONE);
        busy      = (state_q == RUN) || (state_q == DONE);
        sum       = sum_q;
        c_out     = c_out_q;
    end

endmodule

// File: tb/tb_byte_serial_add_ctrl.sv
// Self-checking bench for byte_serial_add_ctrl (NBYTES=4) against an arithmetic reference model.
module tb_byte_serial_add_ctrl;

    localparam int NBYTES  = 4;
    localparam int W       = 8 * NBYTES;
    localparam int TIMEOUT = 40;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         c_in = 1'b0;
    logic         op_sub = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] sum;
    logic         c_out;
    logic         busy;

    int vectors = 0;
    int errors  = 0;

    always #5 clk = ~clk;

    byte_serial_add_ctrl #(.NBYTES(NBYTES)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .c_in      (c_in),
`ifdef SUBTRACT_EN
        .op_sub    (op_sub),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .c_out     (c_out),
        .busy      (busy)
    );

    // Reference: the full-width result {c_out, sum} as plain integer arithmetic.
    function automatic logic [W:0] ref_result(input logic [W-1:0] x, input logic [W-1:0] y,
                                              input logic ci, input logic sub);
        if (sub) return {1'b0, x} + {1'b0, ~y} + (W+1)'(1);
        return {1'b0, x} + {1'b0, y} + {{W{1'b0}}, ci};
    endfunction

    task automatic drive(input logic [W-1:0] x, input logic [W-1:0] y, input logic ci, input logic sub);
        a      = x;
        b      = y;
        c_in   = ci;
        op_sub = sub;
    endtask

    // Offers one operation and returns on the negedge just after the accept edge, with inputs scrambled.
    task automatic issue(input logic [W-1:0] x, input logic [W-1:0] y, input logic ci, input logic sub);
        int n;
        @(negedge clk);
        drive(x, y, ci, sub);
        in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < TIMEOUT) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            vectors++;
            errors++;
            $display("[TB] FAIL accept_timeout: in_ready=%b after %0d cycles, required 1", in_ready, n);
        end
        @(negedge clk);
        in_valid = 1'b0;
        drive(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom));
    endtask

    // Counts clock edges from the accept edge until out_valid is seen.
    task automatic collect(output logic [W-1:0] s, output logic co, output int lat);
        lat = 0;
        while (!out_valid && lat < TIMEOUT) begin
            @(negedge clk);
            lat++;
        end
        s  = sum;
        co = c_out;
    endtask

    task automatic handshake();
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(negedge clk);
        vectors++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_in_ready: got %b want 1", in_ready); end
        vectors++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_out_valid: got %b want 0", out_valid); end
        vectors++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b want 0", busy); end
        vectors++; if (sum !== '0) begin errors++; $display("[TB] FAIL reset_sum: got %h want 0", sum); end
        vectors++; if (c_out !== 1'b0) begin errors++; $display("[TB] FAIL reset_c_out: got %b want 0", c_out); end
        rst_n = 1'b1;
        @(negedge clk);
        vectors++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL post_reset_in_ready: got %b want 1", in_ready); end
    endtask

    task automatic run_and_check(input string name, input logic [W-1:0] x, input logic [W-1:0] y,
                                 input logic ci, input logic sub);
        logic [W-1:0] s;
        logic         co;
        int           lat;
        logic [W:0]   exp;
        exp = ref_result(x, y, ci, sub);
        issue(x, y, ci, sub);
        vectors++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL %s_busy: got %b want 1", name, busy); end
        collect(s, co, lat);
        vectors++; if (lat != NBYTES) begin errors++; $display("[TB] FAIL %s_latency: got %0d want %0d", name, lat, NBYTES); end
        vectors++; if (s !== exp[W-1:0]) begin errors++; $display("[TB] FAIL %s_sum: got %h want %h", name, s, exp[W-1:0]); end
        vectors++; if (co !== exp[W]) begin errors++; $display("[TB] FAIL %s_c_out: got %b want %b", name, co, exp[W]); end
        handshake();
        vectors++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL %s_release: in_ready got %b want 1", name, in_ready); end
    endtask

    task automatic test_add_directed();
        run_and_check("carry_byte0", 32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0);
        run_and_check("carry_all", 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0);
        run_and_check("max_plus_max", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0);
    endtask

    task automatic test_add_random();
        for (int i = 0; i < 20; i++) begin
            run_and_check("random", W'($urandom), W'($urandom), 1'($urandom), 1'b0);
        end
    endtask

    task automatic test_backpressure();
        logic [W-1:0] x1, y1, x2, y2, s;
        logic         co;
        int           lat;
        logic [W:0]   exp1, exp2;
        x1 = W'($urandom); y1 = W'($urandom);
        x2 = W'($urandom); y2 = W'($urandom);
        exp1 = ref_result(x1, y1, 1'b0, 1'b0);
        exp2 = ref_result(x2, y2, 1'b1, 1'b0);
        issue(x1, y1, 1'b0, 1'b0);
        collect(s, co, lat);
        vectors++; if (s !== exp1[W-1:0]) begin errors++; $display("[TB] FAIL bp_sum: got %h want %h", s, exp1[W-1:0]); end
        drive(x2, y2, 1'b1, 1'b0);
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            vectors++; if (sum !== exp1[W-1:0]) begin errors++; $display("[TB] FAIL bp_hold_sum: got %h want %h", sum, exp1[W-1:0]); end
            vectors++; if (c_out !== exp1[W]) begin errors++; $display("[TB] FAIL bp_hold_c_out: got %b want %b", c_out, exp1[W]); end
            vectors++; if (in_ready !== 1'b0) begin errors++; $display("[TB] FAIL bp_hold_in_ready: got %b want 0", in_ready); end
            vectors++; if (out_valid !== 1'b1) begin errors++; $display("[TB] FAIL bp_hold_out_valid: got %b want 1", out_valid); end
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        vectors++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL bp_after_hs_out_valid: got %b want 0", out_valid); end
        vectors++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL bp_after_hs_in_ready: got %b want 1", in_ready); end
        @(negedge clk);
        in_valid = 1'b0;
        drive(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom));
        vectors++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL bp_second_accept: busy got %b want 1", busy); end
        collect(s, co, lat);
        vectors++; if (s !== exp2[W-1:0]) begin errors++; $display("[TB] FAIL bp_second_sum: got %h want %h", s, exp2[W-1:0]); end
        vectors++; if (co !== exp2[W]) begin errors++; $display("[TB] FAIL bp_second_c_out: got %b want %b", co, exp2[W]); end
        handshake();
    endtask

    task automatic test_reset_mid_run();
        int seen;
        issue(W'($urandom), W'($urandom), 1'b1, 1'b0);
        repeat (2) @(negedge clk);
        vectors++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL midrun_busy: got %b want 1", busy); end
        rst_n = 1'b0;
        #1;
        vectors++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL midrun_in_ready: got %b want 1", in_ready); end
        vectors++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL midrun_busy_reset: got %b want 0", busy); end
        vectors++; if (sum !== '0) begin errors++; $display("[TB] FAIL midrun_sum: got %h want 0", sum); end
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        vectors++; if (seen != 0) begin errors++; $display("[TB] FAIL midrun_no_out_valid: got %0d pulses want 0", seen); end
        vectors++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL midrun_release_in_ready: got %b want 1", in_ready); end
        run_and_check("after_reset", 32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0);
    endtask

`ifdef SUBTRACT_EN
    task automatic test_subtract();
        run_and_check("sub_pos", 32'h0000_0007, 32'h0000_0005, 1'b0, 1'b1);
        run_and_check("sub_neg", 32'h0000_0005, 32'h0000_0007, 1'b1, 1'b1);
        for (int i = 0; i < 6; i++) begin
            run_and_check("sub_random", W'($urandom), W'($urandom), 1'($urandom), 1'b1);
        end
    endtask
`endif

    task automatic test_back_to_back();
        logic [W-1:0] x1, y1, x2, y2, s;
        logic         c1, c2, co;
        int           lat;
        logic [W:0]   exp1, exp2;
        x1 = W'($urandom); y1 = W'($urandom); c1 = 1'($urandom);
        x2 = W'($urandom); y2 = W'($urandom); c2 = 1'($urandom);
        exp1 = ref_result(x1, y1, c1, 1'b0);
        exp2 = ref_result(x2, y2, c2, 1'b0);
        out_ready = 1'b1;
        @(negedge clk);
        drive(x1, y1, c1, 1'b0);
        in_valid = 1'b1;
        @(negedge clk);
        vectors++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL b2b_first_accept: busy got %b want 1", busy); end
        drive(x2, y2, c2, 1'b0);
        collect(s, co, lat);
        vectors++; if (lat != NBYTES) begin errors++; $display("[TB] FAIL b2b_first_latency: got %0d want %0d", lat, NBYTES); end
        vectors++; if (s !== exp1[W-1:0]) begin errors++; $display("[TB] FAIL b2b_first_sum: got %h want %h", s, exp1[W-1:0]); end
        vectors++; if (co !== exp1[W]) begin errors++; $display("[TB] FAIL b2b_first_c_out: got %b want %b", co, exp1[W]); end
        @(negedge clk);
        vectors++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL b2b_idle_gap: in_ready got %b want 1", in_ready); end
        @(negedge clk);
        vectors++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL b2b_second_accept: busy got %b want 1", busy); end
        in_valid = 1'b0;
        drive(W'($urandom), W'($urandom), 1'($urandom), 1'b0);
        collect(s, co, lat);
        vectors++; if (lat != NBYTES) begin errors++; $display("[TB] FAIL b2b_second_latency: got %0d want %0d", lat, NBYTES); end
        vectors++; if (s !== exp2[W-1:0]) begin errors++; $display("[TB] FAIL b2b_second_sum: got %h want %h", s, exp2[W-1:0]); end
        vectors++; if (co !== exp2[W]) begin errors++; $display("[TB] FAIL b2b_second_c_out: got %b want %b", co, exp2[W]); end
        @(negedge clk);
        out_ready = 1'b0;
        vectors++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL b2b_final_idle: in_ready got %b want 1", in_ready); end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        test_reset();
        test_add_directed();
        test_add_random();
        test_backpressure();
        test_reset_mid_run();
`ifdef SUBTRACT_EN
        test_subtract();
`endif
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
